// File: rtl/if_pkg.sv
// Shared types and sizing for the instruction fetch unit.
// Define IF_PREFETCH_EN for a 2-entry prefetch buffer; otherwise a single entry is used.
package if_pkg;

  localparam int unsigned INSTR_BYTES = 4;

`ifdef IF_PREFETCH_EN
  localparam int unsigned FETCH_DEPTH = 2;
`else
  localparam int unsigned FETCH_DEPTH = 1;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_fifo.sv
// Shift-register FIFO of fetched {instr, pc} entries; slot 0 is always the head.
// Vacated slots are cleared so an empty FIFO presents an all-zero head.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;

  // Pop shifts toward the head; push lands behind the surviving entries.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    count_d = count_q;
    wr_idx  = count_q - CW'(pop);
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) mem_d[i] = mem_q[i + 1];
        mem_d[DEPTH-1] = '0;
      end
      if (push) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (wr_idx == CW'(i)) mem_d[i] = wdata;
        end
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      count_q <= count_d;
    end
  end

  assign head  = mem_q[0];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues in-order word fetches, buffers responses, handles decode redirects.
// Buffer depth and outstanding limit follow IF_PREFETCH_EN (2 when defined, else 1).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pcplus4,
  output logic        instr_valid
);

  localparam int unsigned DEPTH = FETCH_DEPTH;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SW    = CW + 1;

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   fpc_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] outst_after_rsp;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] drop_d;
  logic [SW-1:0] budget;
  logic [31:0]   rsp_pc;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  head;
  fetch_entry_t  wentry;

  assign instr_valid     = !fifo_empty;
  assign pop             = instr_valid && !stallF && !pcsrcD;
  assign budget          = SW'(fifo_count) + SW'(outst_q) - SW'(pop);
  assign outst_after_rsp = outst_q - CW'(imem_rvalid);
  // In RUN every in-flight request is live, so the oldest one sits outst_q words behind fpc.
  assign rsp_pc          = fpc_q - (32'(outst_q) * 32'(INSTR_BYTES));
  assign wentry          = '{instr: imem_rdata, pc: rsp_pc};

  // Next-state, request and push decisions.
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    imem_req = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        push     = imem_rvalid && !pcsrcD && (!fifo_full || pop);
        imem_req = !pcsrcD && (budget < SW'(DEPTH));
        if (pcsrcD) begin
          drop_d  = outst_after_rsp;
          state_d = (outst_after_rsp != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        drop_d  = drop_q - CW'(imem_rvalid);
        state_d = (drop_d == '0) ? RUN : DRAIN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      fpc_q   <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      outst_q <= outst_after_rsp + CW'(imem_req);
      if (pcsrcD) begin
        fpc_q <= pcbranchD;
      end else if (imem_req) begin
        fpc_q <= fpc_q + 32'(INSTR_BYTES);
      end
    end
  end

  if_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(pcsrcD),
    .wdata(wentry),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign imem_addr = fpc_q;
  assign instr     = instr_valid ? head.instr : '0;
  assign pcplus4   = instr_valid ? (head.pc + 32'(INSTR_BYTES)) : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: in-order random-latency memory plus an
// instruction-stream model (expected next PC to deliver / to request).
module tb_if_fetch_unit;

  localparam int unsigned DEPTH    = if_pkg::FETCH_DEPTH;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF;
  logic        pcsrcD;
  logic [31:0] pcbranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pcplus4;
  logic        instr_valid;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallF     (stallF),
    .pcsrcD     (pcsrcD),
    .pcbranchD  (pcbranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .pcplus4    (pcplus4),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // memory model state
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  int unsigned pend_epoch[$];
  int unsigned cyc, epoch, last_due, lat_min, lat_max, max_inflight, consumed_cnt;

  // stream model and per-cycle observations
  logic [31:0] exp_pc, exp_req, e_head, e_req;
  logic        e_stale;
  logic        o_req, o_valid, o_consumed;
  logic [31:0] o_addr, o_instr, o_pc4;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[17:2]};
  endfunction

  // One clock cycle: drive inputs, sample outputs at negedge, advance models at posedge.
  task automatic cycle(input logic s, input logic b, input logic [31:0] t);
    int unsigned lat, due;
    stallF    = s;
    pcsrcD    = b;
    pcbranchD = t;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
    e_head  = exp_pc;
    e_req   = exp_req;
    e_stale = 1'b0;
    foreach (pend_epoch[i]) if (pend_epoch[i] != epoch) e_stale = 1'b1;
    @(negedge clk);
    o_req      = imem_req;
    o_addr     = imem_addr;
    o_valid    = instr_valid;
    o_instr    = instr;
    o_pc4      = pcplus4;
    o_consumed = o_valid && !s && !b;
    if (o_consumed) begin
      exp_pc = exp_pc + 32'd4;
      consumed_cnt++;
    end
    if (o_req) exp_req = exp_req + 32'd4;
    @(posedge clk);
    if (imem_rvalid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      void'(pend_epoch.pop_front());
    end
    if (o_req) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend_addr.push_back(o_addr);
      pend_due.push_back(due);
      pend_epoch.push_back(epoch);
      last_due = due;
    end
    if (b) begin
      exp_pc  = t;
      exp_req = t;
      epoch++;
    end
    if (pend_addr.size() > int'(max_inflight)) max_inflight = pend_addr.size();
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    rst_n       = 1'b0;
    stallF      = 1'b0;
    pcsrcD      = 1'b0;
    pcbranchD   = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend_addr.delete();
    pend_due.delete();
    pend_epoch.delete();
    epoch++;
    last_due     = 0;
    max_inflight = 0;
    exp_pc       = RESET_PC;
    exp_req      = RESET_PC;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stallF      = 1'($urandom());
      pcsrcD      = 1'($urandom());
      pcbranchD   = $urandom();
      imem_rvalid = 1'($urandom());
      imem_rdata  = $urandom();
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== '0 || pcplus4 !== '0 ||
          imem_addr !== RESET_PC) begin
        failures++;
        $display("FAIL reset_outputs req=%b valid=%b instr=%h pc4=%h addr=%h exp all 0, addr=%h",
                 imem_req, instr_valid, instr, pcplus4, imem_addr, RESET_PC);
      end
    end
    reset_dut();
  endtask

  task automatic test_startup();
    logic [31:0] got[$];
    logic [31:0] exp_seq[3] = '{32'h4, 32'h8, 32'hC};
    lat_min = 1;
    lat_max = 1;
    reset_dut();
    for (int c = 1; c <= 14; c++) begin
      cycle(1'b0, 1'b0, '0);
      if (c == 1) begin
        checks++;
        if (o_req !== 1'b0) begin
          failures++;
          $display("FAIL startup_boot_no_req got=%b exp=0", o_req);
        end
      end
      if (c == 2) begin
        checks++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
          failures++;
          $display("FAIL startup_first_req req=%b addr=%h exp req=1 addr=%h", o_req, o_addr, RESET_PC);
        end
      end
      if (c == 3) begin
        checks++;
        if (o_valid !== 1'b0) begin
          failures++;
          $display("FAIL startup_valid_c3 got=%b exp=0", o_valid);
        end
      end
      if (c == 4) begin
        checks++;
        if (o_valid !== 1'b1 || o_pc4 !== 32'h4 || o_instr !== mem_data(32'h0)) begin
          failures++;
          $display("FAIL startup_valid_c4 valid=%b pc4=%h instr=%h exp 1 %h %h",
                   o_valid, o_pc4, o_instr, 32'h4, mem_data(32'h0));
        end
      end
      if (o_req) begin
        checks++;
        if (o_addr !== e_req) begin
          failures++;
          $display("FAIL startup_addr got=%h exp=%h", o_addr, e_req);
        end
      end
      if (o_consumed) got.push_back(o_pc4);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== exp_seq[i]) begin
        failures++;
        $display("FAIL startup_pcplus4_seq idx=%0d got=%h exp=%h", i,
                 (got.size() > i) ? got[i] : 32'hx, exp_seq[i]);
      end
    end
    checks++;
    if (max_inflight > DEPTH) begin
      failures++;
      $display("FAIL startup_outstanding got=%0d exp<=%0d", max_inflight, DEPTH);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_i, held_p, prev;
    logic        got;
    int unsigned n;
    lat_min = 1;
    lat_max = 3;
    got     = 1'b0;
    held_i  = '0;
    held_p  = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_valid) begin
        got    = 1'b1;
        held_i = o_instr;
        held_p = o_pc4;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL stall_wait_valid no valid within 20 cycles exp valid");
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, '0);
      checks++;
      if (o_valid !== 1'b1 || o_instr !== held_i || o_pc4 !== held_p) begin
        failures++;
        $display("FAIL stall_hold k=%0d valid=%b instr=%h pc4=%h exp 1 %h %h",
                 k, o_valid, o_instr, o_pc4, held_i, held_p);
      end
    end
    checks++;
    if (max_inflight > DEPTH) begin
      failures++;
      $display("FAIL stall_outstanding got=%0d exp<=%0d", max_inflight, DEPTH);
    end
    n    = 0;
    prev = held_p - 32'd4;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (o_consumed) begin
        checks++;
        if (o_pc4 !== prev + 32'd4 || o_instr !== mem_data(o_pc4 - 32'd4)) begin
          failures++;
          $display("FAIL stall_release_seq pc4=%h instr=%h exp %h %h",
                   o_pc4, o_instr, prev + 32'd4, mem_data(prev));
        end
        prev = o_pc4;
        n++;
      end
    end
    checks++;
    if (n < 3) begin
      failures++;
      $display("FAIL stall_release_progress got=%0d exp>=3", n);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] dropped[$];
    logic        ready, seen_req, seen_cons;
    lat_min = 3;
    lat_max = 3;
    ready   = 1'b0;
    for (int k = 0; k < 40 && !ready; k++) begin
      if (pend_addr.size() == int'(DEPTH) && pend_due[0] > cyc) ready = 1'b1;
      else cycle(1'b0, 1'b0, '0);
    end
    checks++;
    if (!ready) begin
      failures++;
      $display("FAIL redirect_setup inflight=%0d exp=%0d", pend_addr.size(), DEPTH);
    end
    foreach (pend_addr[i]) dropped.push_back(mem_data(pend_addr[i]));
    cycle(1'b0, 1'b1, 32'h100);
    checks++;
    if (o_req !== 1'b0) begin
      failures++;
      $display("FAIL redirect_same_cycle_req got=%b exp=0", o_req);
    end
    seen_req  = 1'b0;
    seen_cons = 1'b0;
    for (int k = 0; k < 30 && !seen_cons; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (o_req && !seen_req) begin
        seen_req = 1'b1;
        checks++;
        if (o_addr !== 32'h100 || e_stale) begin
          failures++;
          $display("FAIL redirect_first_req addr=%h stale_pending=%b exp 00000100 0", o_addr, e_stale);
        end
      end
      if (o_valid) begin
        foreach (dropped[i]) begin
          checks++;
          if (o_instr === dropped[i]) begin
            failures++;
            $display("FAIL redirect_dropped_seen instr=%h exp never", o_instr);
          end
        end
      end
      if (o_consumed) begin
        seen_cons = 1'b1;
        checks++;
        if (o_pc4 !== 32'h104 || o_instr !== mem_data(32'h100)) begin
          failures++;
          $display("FAIL redirect_first_delivery pc4=%h instr=%h exp 00000104 %h",
                   o_pc4, o_instr, mem_data(32'h100));
        end
      end
    end
    checks++;
    if (!seen_cons) begin
      failures++;
      $display("FAIL redirect_timeout no delivery within 30 cycles exp delivery");
    end
  endtask

  task automatic test_coincident();
    logic [31:0] dropped;
    logic        ready, seen_cons;
    lat_min = 2;
    lat_max = 2;
    ready   = 1'b0;
    dropped = '0;
    for (int k = 0; k < 40 && !ready; k++) begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc) ready = 1'b1;
      else cycle(1'b0, 1'b0, '0);
    end
    checks++;
    if (!ready) begin
      failures++;
      $display("FAIL coincident_setup no response pending got=0 exp=1");
    end
    if (ready) dropped = mem_data(pend_addr[0]);
    cycle(1'b0, 1'b1, 32'h200);
    seen_cons = 1'b0;
    for (int k = 0; k < 30 && !seen_cons; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (o_valid) begin
        checks++;
        if (o_instr === dropped) begin
          failures++;
          $display("FAIL coincident_dropped_seen instr=%h exp never", o_instr);
        end
      end
      if (o_consumed) begin
        seen_cons = 1'b1;
        checks++;
        if (o_pc4 !== 32'h204) begin
          failures++;
          $display("FAIL coincident_first_delivery pc4=%h exp=00000204", o_pc4);
        end
      end
    end
    checks++;
    if (!seen_cons) begin
      failures++;
      $display("FAIL coincident_timeout no delivery within 30 cycles exp delivery");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] reqs[$];
    logic [31:0] cons[$];
    lat_min = 1;
    lat_max = 2;
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int k = 0; k < 40 && cons.size() < 2; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (o_req) reqs.push_back(o_addr);
      if (o_consumed) begin
        cons.push_back(o_pc4);
        checks++;
        if (o_instr !== mem_data(o_pc4 - 32'd4)) begin
          failures++;
          $display("FAIL wrap_instr got=%h exp=%h", o_instr, mem_data(o_pc4 - 32'd4));
        end
      end
    end
    checks++;
    if (reqs.size() < 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_req_addr got=%h,%h exp=fffffffc,00000000",
               (reqs.size() > 0) ? reqs[0] : 32'hx, (reqs.size() > 1) ? reqs[1] : 32'hx);
    end
    checks++;
    if (cons.size() < 2 || cons[0] !== 32'h0 || cons[1] !== 32'h4) begin
      failures++;
      $display("FAIL wrap_pcplus4 got=%h,%h exp=00000000,00000004",
               (cons.size() > 0) ? cons[0] : 32'hx, (cons.size() > 1) ? cons[1] : 32'hx);
    end
  endtask

  task automatic test_random();
    logic        s, b;
    logic [31:0] t;
    int unsigned start_cnt;
    lat_min   = 1;
    lat_max   = 4;
    start_cnt = consumed_cnt;
    for (int k = 0; k < 400; k++) begin
      s = ($urandom_range(9, 0) < 3);
      b = ($urandom_range(19, 0) == 0);
      t = $urandom() & 32'hFFFF_FFFC;
      cycle(s, b, t);
      checks++;
      if (o_valid) begin
        if (o_pc4 !== e_head + 32'd4 || o_instr !== mem_data(e_head)) begin
          failures++;
          $display("FAIL random_head cyc=%0d pc4=%h instr=%h exp %h %h",
                   cyc, o_pc4, o_instr, e_head + 32'd4, mem_data(e_head));
        end
      end else if (o_instr !== '0 || o_pc4 !== '0) begin
        failures++;
        $display("FAIL random_idle_zero cyc=%0d instr=%h pc4=%h exp 0 0", cyc, o_instr, o_pc4);
      end
      if (o_req) begin
        checks++;
        if (o_addr !== e_req || b || e_stale) begin
          failures++;
          $display("FAIL random_req cyc=%0d addr=%h redirect=%b stale=%b exp addr=%h no redirect/stale",
                   cyc, o_addr, b, e_stale, e_req);
        end
      end
    end
    checks++;
    if (max_inflight > DEPTH) begin
      failures++;
      $display("FAIL random_outstanding got=%0d exp<=%0d", max_inflight, DEPTH);
    end
    checks++;
    if (consumed_cnt - start_cnt < 20) begin
      failures++;
      $display("FAIL random_progress got=%0d exp>=20", consumed_cnt - start_cnt);
    end
  endtask

  task automatic test_reset_drain();
    logic ready, seen_cons;
    lat_min = 4;
    lat_max = 4;
    ready   = 1'b0;
    for (int k = 0; k < 40 && !ready; k++) begin
      if (pend_due.size() > 0 && pend_due[0] > cyc) ready = 1'b1;
      else cycle(1'b0, 1'b0, '0);
    end
    checks++;
    if (!ready) begin
      failures++;
      $display("FAIL rstdrain_setup no request in flight got=0 exp>0");
    end
    cycle(1'b0, 1'b1, 32'h300);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== '0 || pcplus4 !== '0 ||
        imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL rstdrain_async req=%b valid=%b instr=%h pc4=%h addr=%h exp 0 0 0 0 %h",
               imem_req, instr_valid, instr, pcplus4, imem_addr, RESET_PC);
    end
    reset_dut();
    lat_min = 1;
    lat_max = 1;
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (o_req !== 1'b0) begin
      failures++;
      $display("FAIL rstdrain_boot_req got=%b exp=0", o_req);
    end
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      failures++;
      $display("FAIL rstdrain_restart req=%b addr=%h exp 1 %h", o_req, o_addr, RESET_PC);
    end
    seen_cons = 1'b0;
    for (int k = 0; k < 20 && !seen_cons; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (o_consumed) begin
        seen_cons = 1'b1;
        checks++;
        if (o_pc4 !== RESET_PC + 32'd4 || o_instr !== mem_data(RESET_PC)) begin
          failures++;
          $display("FAIL rstdrain_first_delivery pc4=%h instr=%h exp %h %h",
                   o_pc4, o_instr, RESET_PC + 32'd4, mem_data(RESET_PC));
        end
      end
    end
    checks++;
    if (!seen_cons) begin
      failures++;
      $display("FAIL rstdrain_timeout no delivery within 20 cycles exp delivery");
    end
  endtask

  initial begin
    epoch        = 0;
    cyc          = 0;
    consumed_cnt = 0;
    lat_min      = 1;
    lat_max      = 1;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_coincident();
    test_wrap();
    test_random();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: stallF  input  1  downstream hold; the head instruction is not consumed.
REQ-005 SHALL have port: pcsrcD  input  1  redirect request from decode.
REQ-006 SHALL have port: pcbranchD  input  32  redirect target.
REQ-007 SHALL have port: imem_req  output  1  fetch request; always accepted in the cycle asserted.
REQ-008 SHALL have port: imem_addr  output  32  word address of the request.
REQ-009 SHALL have port: imem_rvalid  input  1  response valid; responses return in order, latency >= 1 cycle.
REQ-010 SHALL have port: imem_rdata  input  32  response instruction.
REQ-011 SHALL have port: instr  output  32  head instruction; 32'b0 when instr_valid = 0.
REQ-012 SHALL have port: pcplus4  output  32  head PC + 4; 32'b0 when instr_valid = 0.
REQ-013 SHALL have port: instr_valid  output  1  the buffer holds a deliverable instruction.

Function
REQ-014 SHALL keep fetch PC fpc; each request drives imem_addr = fpc; fpc advances by 4 per request; wrap at 2^32 is modular.
REQ-015 SHALL use a FIFO of {instr, pc} entries, DEPTH = 2, with at most 2 requests outstanding.
REQ-016 SHALL issue a request only when occupancy + outstanding - pop < DEPTH and state = RUN.
REQ-017 SHALL push non-dropped responses into the FIFO; pop when instr_valid & !stallF & !pcsrcD.
REQ-018 SHALL allow push and pop in the same cycle when full, leaving occupancy unchanged.
REQ-019 SHALL implement FSM states BOOT, RUN and DRAIN.
REQ-020 SHALL transition BOOT->RUN unconditionally one cycle after reset release, with no request issued in BOOT.
REQ-021 On pcsrcD, SHALL flush the FIFO, set fpc <= pcbranchD, load drop_cnt <= outstanding (counted after that cycle's response), and enter DRAIN if that value is > 0, else RUN.
REQ-022 In DRAIN, SHALL discard each imem_rvalid and decrement drop_cnt, returning to RUN when drop_cnt reaches 0; SHALL issue no requests.
REQ-023 SHALL give pcsrcD priority over stallF.
REQ-024 SHALL discard an imem_rvalid that coincides with pcsrcD (it counts as in-flight before the flush).
REQ-025 SHALL apply a second pcsrcD during DRAIN: retarget fpc and leave drop_cnt decrementing.
REQ-026 First request after a redirect SHALL occur the cycle after drop_cnt reaches 0, or the cycle after pcsrcD when nothing was in flight.
REQ-027 SHALL drive outputs registered from the FIFO head only; no combinational path imem_rdata->instr.

Reset
REQ-028 SHALL set, while rst_n = 0: fpc = RESET_PC, FIFO empty, outstanding = 0, drop_cnt = 0, state = BOOT, imem_req = 0, instr_valid = 0, instr = 0, pcplus4 = 0.
REQ-029 SHALL discard all in-flight responses on reset mid-operation; the memory model is also reset.

Configuration
REQ-030 SHALL use macro IF_PREFETCH_EN to select buffering depth.
REQ-031 With IF_PREFETCH_EN defined, SHALL use DEPTH = 2 and 2 outstanding requests.
REQ-032 Without IF_PREFETCH_EN, SHALL use DEPTH = 1 and 1 outstanding request, with all other behaviour unchanged.

Structure
REQ-033 SHALL place in package if_pkg: typedef fetch_entry_t {instr[31:0], pc[31:0]}; enum fetch_state_e {BOOT, RUN, DRAIN}; constant INSTR_BYTES = 4.
REQ-034 SHALL implement the FIFO as sub-module if_fetch_fifo (parameter DEPTH; push/pop/flush; full/empty/count).
REQ-035 SHALL keep the FSM, fpc, outstanding counter and drop_cnt in if_fetch_unit.

Verification
REQ-036 SHALL cover: reset release, 1-cycle memory, no stall -> first imem_addr 0x0 in cycle 2; instr_valid from cycle 4; pcplus4 sequence 0x4, 0x8, 0xC.
REQ-037 SHALL cover: stallF high 5 cycles -> instr/pcplus4 held constant; no more than 2 requests outstanding; no instruction lost on release.
REQ-038 SHALL cover: pcsrcD with pcbranchD = 0x100 and 2 in flight -> both responses dropped; next imem_addr = 0x100; delivered pcplus4 = 0x104.
REQ-039 SHALL cover: imem_rvalid coincident with pcsrcD -> that instruction never appears on instr.
REQ-040 SHALL cover: fpc = 0xFFFF_FFFC -> next imem_addr = 0x0000_0000.
REQ-041 SHALL cover: rst_n asserted mid-DRAIN -> all outputs 0 asynchronously; restart from RESET_PC. Repeat REQ-036 with IF_PREFETCH_EN undefined -> never more than 1 outstanding.
